dvs_aer_transmitter: RTL and testbench
======================================

# dvs_aer_transmitter

Synthesizable AER sender: the sending end of the DVS-to-interface link that `dvs_aer_receiver` terminates. It accepts pixel events (x, y, polarity) on a valid/ready port and serializes each event onto the 10-bit AER bus as a Y word followed by an X word. Each word uses a four-phase REQ/ACK handshake. It drives the receiver in system-level loopback and in FPGA self-test, and it emulates the DVS camera's row-coalescing behaviour.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: clock cycles that `aer`/`xsel` are held stable before `req` rises. Legal range 1..15.
- `ROW_TIMEOUT_CYCLES`, default 64: idle cycles after which the cached row is invalidated. Legal range 1..65535.

Ports:
- `clk` in 1: single clock. Period is `CLK_PERIOD_NS` from `dvs_ravens_pkg`.
- `rst_n` in 1: asynchronous, active-low reset.
- `evt_valid` in 1: an event is offered.
- `evt_ready` out 1: the block can accept an event.
- `evt_x` in 9: pixel X address.
- `evt_y` in 9: pixel Y address.
- `evt_pol` in 1: event polarity.
- `evt_drop` out 1: one-cycle pulse when an out-of-range event is discarded.
- `aer` out 10: AER data bus.
- `xsel` out 1: word type. 0 = Y word, 1 = X word.
- `req` out 1: AER request.
- `ack` in 1: AER acknowledge from the receiver. Asynchronous to `clk`.

## Operation
- Word formats:
  - Y word: `aer = {1'b0, y[8:0]}`, `xsel = 0`.
  - X word: `aer = {x[8:0], pol}`, `xsel = 1`.
- Synchronizer: `ack` passes through a 2-flop synchronizer. Its output `ack_s` is the only ack the FSM sees.
- States: IDLE, Y_SETUP, Y_REQ, Y_REL, X_SETUP, X_REQ, X_REL.
- IDLE:
  - `evt_ready = 1`.
  - On `evt_valid & evt_ready`, the block checks the address range.
  - If `evt_x >= DVS_WIDTH_PXLS` or `evt_y >= DVS_HEIGHT_PXLS`: pulse `evt_drop`, stay in IDLE, bus unchanged.
  - If the row matches the cache (`row_valid` and `evt_y == last_y`): go to X_SETUP.
  - Otherwise: go to Y_SETUP.
- On accept, the X, Y and polarity fields are captured in registers.
- Y_SETUP / X_SETUP:
  - The word is loaded onto `aer`/`xsel` on the entering edge.
  - A setup counter runs for `SETUP_CYCLES` cycles, then the FSM moves to \*_REQ.
- Y_REQ / X_REQ: `req = 1`. Wait for `ack_s = 1`, then move to \*_REL.
- Y_REL / X_REL: `req = 0`. Wait for `ack_s = 0`.
  - From Y_REL: go to X_SETUP.
  - From X_REL: go to IDLE, set `last_y` to the captured Y and `row_valid = 1`.
- Bus stability: `aer` and `xsel` stay constant from \*_SETUP entry until \*_REL exit. After an event the bus holds the last X word.
- Row timer:
  - Counts consecutive cycles spent in IDLE without an accept.
  - At `ROW_TIMEOUT_CYCLES` it clears `row_valid`.
  - It resets to 0 on every accept.
  - It saturates; it does not wrap.
- `evt_ready` is 0 in every state except IDLE.

## Timing
- Reset values: `aer = 0`, `xsel = 0`, `req = 0`, `evt_ready = 0`, `evt_drop = 0`. Also `row_valid = 0`, `last_y = 0`, FSM in IDLE.
- Ready after reset: `evt_ready` is registered and rises on the first clock edge after `rst_n` is released.
- Accept edge:
  - Accept happens at edge N. The first word appears on `aer` after edge N.
  - `req` rises after edge N + `SETUP_CYCLES`.
- `req` fall: 1 edge after `ack_s` is seen high. That is 2–3 clock edges after `ack` rises.
- Next word or ready: the next word loads, or `evt_ready` returns, 1 edge after `ack_s` is seen low.
- `evt_drop` is asserted in the cycle after the accept edge, for exactly one cycle.
- Full four-phase order is always preserved. `req` never rises while `ack_s = 1`; if `ack_s` is still high on \*_REQ entry, the FSM waits for the high→low→high cycle.
- Reset mid-handshake:
  - `req`, `aer` and `xsel` clear immediately (asynchronous).
  - The cached row is invalidated.
  - The in-flight event is lost.
- Simultaneous row timeout and accept: the accept wins. The comparison uses the pre-clear `row_valid`, and the timer resets.

## Configuration
- Macro: `DVS_AER_TX_ROW_SKIP_EN`.
- Defined: row coalescing as described above. The Y word is omitted when the row is unchanged and the cache has not timed out.
- Undefined: `row_valid`, `last_y` and the row timer are not built. Every accepted event sends a Y word followed by an X word.

## Test plan
- Single event, x=0x05A, y=0x03C, pol=1, after reset:
  - Y word `aer = 0x03C`, `xsel = 0`.
  - Then X word `aer = 0x0B5`, `xsel = 1`.
  - Each word gets a full handshake; `evt_ready` returns after the second ack falls.
- Two events on row y=0x010, 3 idle cycles apart: the second event produces only an X word.
  - With the macro undefined, both events produce a Y word.
- Same-row events separated by `ROW_TIMEOUT_CYCLES` + 1 idle cycles: the second event resends the Y word.
- Event x=`DVS_WIDTH_PXLS`: one `evt_drop` pulse, `req` stays 0, bus unchanged, `evt_ready` stays 1.
- Receiver model delaying `ack` rise by 20 cycles and fall by 7 cycles:
  - `aer` stable throughout each word.
  - `req` falls no earlier than 2 edges after `ack` rises.
  - No `req` rise while `ack = 1`.
- Assert `rst_n = 0` while in X_REQ: `req` goes to 0 immediately; after release, the next event sends its Y word.

Source files
------------

// File: rtl/dvs_aer_transmitter.sv
// AER sender: serializes (x, y, pol) pixel events into Y/X words over a four-phase REQ/ACK bus.
// Optional row coalescing (Y word skipped for an unchanged row) is built when DVS_AER_TX_ROW_SKIP_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | evt_ready high, waiting for an event
// Y_SETUP | Y word on the bus, waiting out the setup time
// Y_REQ   | req high, waiting for ack_s high
// Y_REL   | req low, waiting for ack_s low
// X_SETUP | X word on the bus, waiting out the setup time
// X_REQ   | req high, waiting for ack_s high
// X_REL   | req low, waiting for ack_s low, then back to IDLE
module dvs_aer_transmitter #(
    parameter int SETUP_CYCLES       = 1,
    parameter int ROW_TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_valid,
    output logic       evt_ready,
    input  logic [8:0] evt_x,
    input  logic [8:0] evt_y,
    input  logic       evt_pol,
    output logic       evt_drop,
    output logic [9:0] aer,
    output logic       xsel,
    output logic       req,
    input  logic       ack
);

    // Sensor array size (DAVIS346-class), mirrored from dvs_ravens_pkg.
    localparam logic [8:0] DVS_WIDTH_PXLS  = 9'd346;
    localparam logic [8:0] DVS_HEIGHT_PXLS = 9'd260;
    localparam logic [3:0] SETUP_LOAD      = 4'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, Y_SETUP, Y_REQ, Y_REL, X_SETUP, X_REQ, X_REL
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] aer_nxt;
    logic       xsel_nxt, req_nxt, ready_nxt, drop_nxt;
    logic [3:0] setup_cnt, setup_cnt_nxt;
    logic [8:0] cap_x, cap_y;
    logic       cap_pol;
    logic       ack_meta, ack_s;
    logic       accept, in_range, row_hit;

    assign accept   = evt_valid && evt_ready;
    assign in_range = (evt_x < DVS_WIDTH_PXLS) && (evt_y < DVS_HEIGHT_PXLS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ack;
            ack_s    <= ack_meta;
        end
    end

`ifdef DVS_AER_TX_ROW_SKIP_EN
    logic        row_valid;
    logic [8:0]  last_y;
    logic [15:0] row_tmr;

    // Uses the pre-clear row_valid, so an accept on the timeout cycle still hits.
    assign row_hit = row_valid && (evt_y == last_y);

    // Down-counter of idle cycles; reaching terminal count drops the cached row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= 1'b0;
            last_y    <= 9'd0;
            row_tmr   <= 16'(ROW_TIMEOUT_CYCLES);
        end else begin
            if (accept) begin
                row_tmr <= 16'(ROW_TIMEOUT_CYCLES);
            end else if (state == IDLE && row_tmr != 16'd0) begin
                row_tmr <= row_tmr - 16'd1;
                if (row_tmr == 16'd1) begin
                    row_valid <= 1'b0;
                end
            end
            if (state == X_REL && !ack_s) begin
                row_valid <= 1'b1;
                last_y    <= cap_y;
            end
        end
    end
`else
    assign row_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        aer_nxt       = aer;
        xsel_nxt      = xsel;
        req_nxt       = req;
        drop_nxt      = 1'b0;
        setup_cnt_nxt = setup_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        drop_nxt = 1'b1;
                    end else if (row_hit) begin
                        state_nxt     = X_SETUP;
                        aer_nxt       = {evt_x, evt_pol};
                        xsel_nxt      = 1'b1;
                        setup_cnt_nxt = SETUP_LOAD;
                    end else begin
                        state_nxt     = Y_SETUP;
                        aer_nxt       = {1'b0, evt_y};
                        xsel_nxt      = 1'b0;
                        setup_cnt_nxt = SETUP_LOAD;
                    end
                end
            end
            // req is only raised once ack_s is low, preserving the four-phase order.
            Y_SETUP, X_SETUP: begin
                if (setup_cnt != 4'd0) begin
                    setup_cnt_nxt = setup_cnt - 4'd1;
                end else if (!ack_s) begin
                    state_nxt = (state == Y_SETUP) ? Y_REQ : X_REQ;
                    req_nxt   = 1'b1;
                end
            end
            Y_REQ, X_REQ: begin
                if (ack_s) begin
                    state_nxt = (state == Y_REQ) ? Y_REL : X_REL;
                    req_nxt   = 1'b0;
                end
            end
            Y_REL: begin
                if (!ack_s) begin
                    state_nxt     = X_SETUP;
                    aer_nxt       = {cap_x, cap_pol};
                    xsel_nxt      = 1'b1;
                    setup_cnt_nxt = SETUP_LOAD;
                end
            end
            X_REL: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aer       <= 10'd0;
            xsel      <= 1'b0;
            req       <= 1'b0;
            evt_ready <= 1'b0;
            evt_drop  <= 1'b0;
            setup_cnt <= 4'd0;
            cap_x     <= 9'd0;
            cap_y     <= 9'd0;
            cap_pol   <= 1'b0;
        end else begin
            aer       <= aer_nxt;
            xsel      <= xsel_nxt;
            req       <= req_nxt;
            evt_ready <= ready_nxt;
            evt_drop  <= drop_nxt;
            setup_cnt <= setup_cnt_nxt;
            if (accept && in_range) begin
                cap_x   <= evt_x;
                cap_y   <= evt_y;
                cap_pol <= evt_pol;
            end
        end
    end

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// Bench for dvs_aer_transmitter: directed events, scoreboard of expected AER words,
// and a receiver model with programmable ack delays.
module tb_dvs_aer_transmitter;

    localparam int         TMO = 64;
    localparam logic [8:0] W   = 9'd346;
    localparam logic [8:0] H   = 9'd260;
`ifdef DVS_AER_TX_ROW_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt_valid = 1'b0;
    logic       evt_ready;
    logic [8:0] evt_x = 9'd0;
    logic [8:0] evt_y = 9'd0;
    logic       evt_pol = 1'b0;
    logic       evt_drop;
    logic [9:0] aer;
    logic       xsel;
    logic       req;
    logic       ack = 1'b0;

    int checks = 0;
    int fails  = 0;
    logic [10:0] exp_q[$];
    int rise_dly = 2;
    int fall_dly = 2;
    int ack_edges = 0;

    dvs_aer_transmitter #(.SETUP_CYCLES(1), .ROW_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_x(evt_x), .evt_y(evt_y), .evt_pol(evt_pol), .evt_drop(evt_drop),
        .aer(aer), .xsel(xsel), .req(req), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Receiver model: ack follows req with programmable rise/fall delays.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && req && !ack) begin
                repeat (rise_dly) @(posedge clk);
                #1;
                if (req) begin
                    ack = 1'b1;
                    while (req) begin
                        @(posedge clk); #1;
                    end
                    repeat (fall_dly) @(posedge clk);
                    #1;
                    ack = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) ack_edges = ack ? ack_edges + 1 : 0;

    // Monitor: pops the expected word at each req rise, checks stability and latency at req fall.
    logic       req_q = 1'b0;
    logic [10:0] word_seen = 11'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_q = 1'b0;
        end else begin
            if (req && !req_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", {xsel, aer});
                end else begin
                    check("aer_word", 32'({xsel, aer}), 32'(exp_q.pop_front()));
                end
                check("ack_low_at_req_rise", 32'(ack), 32'd0);
                word_seen = {xsel, aer};
            end else if (!req && req_q) begin
                check("bus_stable", 32'({xsel, aer}), 32'(word_seen));
                check("req_fall_min_2_edges", 32'(ack_edges >= 2), 32'd1);
            end
            req_q = req;
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (evt_ready !== 1'b1 && n < 2000);
        ok = (evt_ready === 1'b1);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout: got evt_ready=%b expected 1", evt_ready);
        end
    endtask

    task automatic send_evt(input logic [8:0] x, input logic [8:0] y, input logic p, input bit exp_y);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        if (exp_y) exp_q.push_back({2'b00, y});
        exp_q.push_back({1'b1, x, p});
        evt_x = x; evt_y = y; evt_pol = p; evt_valid = 1'b1;
        @(posedge clk); #1;
        evt_valid = 1'b0;
        @(negedge clk);
        check("ready_low_after_accept", 32'(evt_ready), 32'd0);
        wait_ready(ok);
        if (ok) check("ack_low_at_ready", 32'(ack), 32'd0);
    endtask

    task automatic drop_evt(input logic [8:0] x, input logic [8:0] y);
        bit ok;
        logic [10:0] bus;
        wait_ready(ok);
        if (!ok) return;
        bus = {xsel, aer};
        evt_x = x; evt_y = y; evt_pol = 1'b1; evt_valid = 1'b1;
        @(posedge clk); #1;
        evt_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", 32'(evt_drop), 32'd1);
        check("drop_ready", 32'(evt_ready), 32'd1);
        check("drop_req", 32'(req), 32'd0);
        check("drop_bus", 32'({xsel, aer}), 32'(bus));
        @(negedge clk);
        check("drop_one_cycle", 32'(evt_drop), 32'd0);
        check("drop_req_later", 32'(req), 32'd0);
    endtask

    initial begin
        bit ok;
        int n;
        repeat (3) @(negedge clk);
        check("rst_aer", 32'(aer), 32'd0);
        check("rst_xsel", 32'(xsel), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_ready", 32'(evt_ready), 32'd0);
        check("rst_drop", 32'(evt_drop), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(evt_ready), 32'd1);

        // Y 0x03C then X {0x05A,1} = 0x0B5
        send_evt(9'h05A, 9'h03C, 1'b1, 1'b1);
        send_evt(9'h011, 9'h010, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        send_evt(9'h0AA, 9'h010, 1'b1, !SKIP);
        repeat (TMO + 1) @(negedge clk);
        send_evt(9'h0AB, 9'h010, 1'b0, 1'b1);

        drop_evt(W, 9'd5);
        drop_evt(9'd5, H);

        rise_dly = 20;
        fall_dly = 7;
        send_evt(9'h150, 9'h020, 1'b1, 1'b1);
        send_evt(9'h001, 9'h020, 1'b0, !SKIP);

        // Reset while the X word is being requested.
        wait_ready(ok);
        exp_q.push_back({2'b00, 9'h030});
        exp_q.push_back({1'b1, 9'h100, 1'b1});
        evt_x = 9'h100; evt_y = 9'h030; evt_pol = 1'b1; evt_valid = 1'b1;
        @(posedge clk); #1;
        evt_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req === 1'b1 && xsel === 1'b1) && n < 2000);
        check("reached_x_req", 32'(req && xsel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_aer", 32'(aer), 32'd0);
        check("midrst_xsel", 32'(xsel), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rise_dly = 2;
        fall_dly = 2;
        send_evt(9'h101, 9'h030, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
